// File: rtl/tt_capture.sv
// Sweeps every input pattern through a combinational function-under-test and
// assembles its truth table and ones-count behind a valid/ready handshake.
module tt_capture #(
  parameter  int NIN    = 7,
  parameter  int SETTLE = 1,
  localparam int TW     = 2**NIN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic [NIN-1:0] probe,
  output logic           probe_vld,
  input  logic           f_in,
  output logic [TW-1:0]  tt,
  output logic [NIN:0]   ones,
  output logic           tt_valid,
  input  logic           tt_ready
);

  localparam logic [3:0]     SETTLE_W = 4'(SETTLE);
  localparam logic [NIN-1:0] LAST_PAT = '1;

  // One-hot so the busy/valid outputs are single flop bits.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SWEEP = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t     state, state_next;
  logic [3:0] w;
  logic       sample;
  logic       last;

  assign sample = (state == SWEEP) && (w == SETTLE_W);
  assign last   = (probe == LAST_PAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SWEEP;
      SWEEP:   if (sample && last) state_next = DONE;
      DONE:    if (tt_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // f_in is only looked at on the final settle cycle of each pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe <= '0;
      w     <= '0;
      tt    <= '0;
      ones  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            probe <= '0;
            w     <= '0;
            tt    <= '0;
            ones  <= '0;
          end
        end
        SWEEP: begin
          if (sample) begin
            tt[probe] <= f_in;
            ones      <= ones + {{NIN{1'b0}}, f_in};
            w         <= '0;
            probe     <= last ? '0 : NIN'(probe + 1'b1);
          end else begin
            w <= 4'(w + 4'd1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state == SWEEP);
    probe_vld = (state == SWEEP);
    tt_valid  = (state == DONE);
  end

endmodule
